// File: rtl/ex_mem_reg_pkg.sv
// Shared definitions for the EX/MEM pipeline register: opcodes, the
// flag-update classification and the saturation clamp values.
package ex_mem_reg_pkg;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_XOR = 4'b0010;
  localparam logic [3:0] OP_AND = 4'b0011;
  localparam logic [3:0] OP_SLL = 4'b0100;
  localparam logic [3:0] OP_SRA = 4'b0101;
  localparam logic [3:0] OP_ROR = 4'b0110;
  localparam logic [3:0] OP_LW  = 4'b1000;
  localparam logic [3:0] OP_SW  = 4'b1001;

  // Clamp values used when an ADD/SUB overflows with saturation enabled.
  localparam logic [15:0] SAT_POS = 16'h7FFF;
  localparam logic [15:0] SAT_NEG = 16'h8000;

  // How an opcode affects the Z/V/N condition flags.
  typedef enum logic [1:0] {
    FLAG_NONE   = 2'd0,
    FLAG_Z_ONLY = 2'd1,
    FLAG_FULL   = 2'd2
  } flag_class_e;

  function automatic flag_class_e flag_class(input logic [3:0] op);
    flag_class_e fc;
    case (op)
      OP_ADD, OP_SUB:                 fc = FLAG_FULL;
      OP_XOR, OP_SLL, OP_SRA, OP_ROR: fc = FLAG_Z_ONLY;
      default:                        fc = FLAG_NONE;
    endcase
    return fc;
  endfunction

endpackage

// File: rtl/ex_flag_reg.sv
// Architectural Z/V/N condition-flag register. Flags change only when
// upd_en is high; which flags change depends on the opcode class.
module ex_flag_reg
  import ex_mem_reg_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int OP_W   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              upd_en,
  input  logic [OP_W-1:0]   opcode,
  input  logic [DATA_W-1:0] result,
  input  logic              ovfl,
  output logic              flag_z,
  output logic              flag_v,
  output logic              flag_n
);

  logic z_q, z_d;
  logic v_q, v_d;
  logic n_q, n_d;
  flag_class_e fc;

  // Next-flag decode: hold by default, update per opcode class.
  always_comb begin
    z_d = z_q;
    v_d = v_q;
    n_d = n_q;
    fc  = flag_class(opcode);
    if (upd_en) begin
      if (fc == FLAG_FULL) begin
        z_d = (result == '0);
        v_d = ovfl;
        n_d = result[DATA_W-1];
      end else if (fc == FLAG_Z_ONLY) begin
        z_d = (result == '0);
      end
    end
  end

  // Flag flops with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      z_q <= 1'b0;
      v_q <= 1'b0;
      n_q <= 1'b0;
    end else begin
      z_q <= z_d;
      v_q <= v_d;
      n_q <= n_d;
    end
  end

  assign flag_z = z_q;
  assign flag_v = v_q;
  assign flag_n = n_q;

endmodule

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register with the architectural condition flags.
// Optional feature: define SATURATE_EN to clamp overflowing ADD/SUB results.
//
// Hazard handshake (sampled at each rising edge, highest priority first):
//   rst_n=0 : everything cleared.
//   flush=1 : MEM slot invalidated, control cleared, data and flags held.
//   stall=1 : every register holds, flags included.
//   else    : capture EX slot; control bits gated by ex_valid; flags update
//             only for a valid instruction.
module ex_mem_reg
  import ex_mem_reg_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int REG_AW = 4,
  parameter int OP_W   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              ex_valid,
  input  logic [OP_W-1:0]   ex_opcode,
  input  logic [DATA_W-1:0] ex_result,
  input  logic              ex_ovfl,
  input  logic [DATA_W-1:0] ex_store_data,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_regwe,
  input  logic              ex_memrd,
  input  logic              ex_memwr,
  output logic              mem_valid,
  output logic [DATA_W-1:0] mem_result,
  output logic [DATA_W-1:0] mem_store_data,
  output logic [REG_AW-1:0] mem_rd,
  output logic              mem_regwe,
  output logic              mem_memrd,
  output logic              mem_memwr,
  output logic              flag_z,
  output logic              flag_v,
  output logic              flag_n
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic [DATA_W-1:0] store_q, store_d;
  logic [REG_AW-1:0] rd_q, rd_d;
  logic              regwe_q, regwe_d;
  logic              memrd_q, memrd_d;
  logic              memwr_q, memwr_d;
  logic [DATA_W-1:0] res_final;
  logic              cap_en;

  // Final result: wrapped sum, or clamped on ADD/SUB overflow when enabled.
  always_comb begin
    res_final = ex_result;
`ifdef SATURATE_EN
    if (((ex_opcode == OP_ADD) || (ex_opcode == OP_SUB)) && ex_ovfl) begin
      res_final = ex_result[DATA_W-1] ? SAT_POS : SAT_NEG;
    end
`endif
  end

  assign cap_en = ~flush & ~stall;

  // Next-state for the pipeline slot: flush beats stall beats capture.
  always_comb begin
    valid_d  = valid_q;
    result_d = result_q;
    store_d  = store_q;
    rd_d     = rd_q;
    regwe_d  = regwe_q;
    memrd_d  = memrd_q;
    memwr_d  = memwr_q;
    if (flush) begin
      valid_d = 1'b0;
      regwe_d = 1'b0;
      memrd_d = 1'b0;
      memwr_d = 1'b0;
    end else if (!stall) begin
      valid_d  = ex_valid;
      result_d = res_final;
      store_d  = ex_store_data;
      rd_d     = ex_rd;
      regwe_d  = ex_regwe & ex_valid;
      memrd_d  = ex_memrd & ex_valid;
      memwr_d  = ex_memwr & ex_valid;
    end
  end

  // Pipeline slot flops with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      result_q <= '0;
      store_q  <= '0;
      rd_q     <= '0;
      regwe_q  <= 1'b0;
      memrd_q  <= 1'b0;
      memwr_q  <= 1'b0;
    end else begin
      valid_q  <= valid_d;
      result_q <= result_d;
      store_q  <= store_d;
      rd_q     <= rd_d;
      regwe_q  <= regwe_d;
      memrd_q  <= memrd_d;
      memwr_q  <= memwr_d;
    end
  end

  ex_flag_reg #(
    .DATA_W (DATA_W),
    .OP_W   (OP_W)
  ) u_flags (
    .clk    (clk),
    .rst_n  (rst_n),
    .upd_en (cap_en & ex_valid),
    .opcode (ex_opcode),
    .result (res_final),
    .ovfl   (ex_ovfl),
    .flag_z (flag_z),
    .flag_v (flag_v),
    .flag_n (flag_n)
  );

  assign mem_valid      = valid_q;
  assign mem_result     = result_q;
  assign mem_store_data = store_q;
  assign mem_rd         = rd_q;
  assign mem_regwe      = regwe_q & valid_q;
  assign mem_memrd      = memrd_q & valid_q;
  assign mem_memwr      = memwr_q & valid_q;

endmodule

// File: tb/tb_ex_mem_reg.sv
// Self-checking bench for ex_mem_reg: directed scenarios followed by
// randomized traffic, all compared against a behavioural model.
module tb_ex_mem_reg;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, flush;
  logic        ex_valid;
  logic [3:0]  ex_opcode;
  logic [15:0] ex_result;
  logic        ex_ovfl;
  logic [15:0] ex_store_data;
  logic [3:0]  ex_rd;
  logic        ex_regwe, ex_memrd, ex_memwr;
  logic        mem_valid;
  logic [15:0] mem_result, mem_store_data;
  logic [3:0]  mem_rd;
  logic        mem_regwe, mem_memrd, mem_memwr;
  logic        flag_z, flag_v, flag_n;

  // clock / reset block
  always #5 clk = ~clk;

  ex_mem_reg dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_result(ex_result),
    .ex_ovfl(ex_ovfl), .ex_store_data(ex_store_data), .ex_rd(ex_rd),
    .ex_regwe(ex_regwe), .ex_memrd(ex_memrd), .ex_memwr(ex_memwr),
    .mem_valid(mem_valid), .mem_result(mem_result),
    .mem_store_data(mem_store_data), .mem_rd(mem_rd),
    .mem_regwe(mem_regwe), .mem_memrd(mem_memrd), .mem_memwr(mem_memwr),
    .flag_z(flag_z), .flag_v(flag_v), .flag_n(flag_n)
  );

  // scoreboard state
  int n_vec = 0;
  int n_err = 0;
  logic [15:0] exp_q[$];
  logic        m_valid, m_regwe, m_memrd, m_memwr, m_z, m_v, m_n;
  logic [15:0] m_result, m_store;
  logic [3:0]  m_rd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, expv, $time);
    end
  endtask

  // Reference model: one pipeline edge, straight from the operating rules.
  task automatic model_edge();
    logic [15:0] r;
    if (!rst_n) begin
      {m_valid, m_regwe, m_memrd, m_memwr, m_z, m_v, m_n} = '0;
      m_result = 0; m_store = 0; m_rd = 0;
    end else if (flush) begin
      m_valid = 0; m_regwe = 0; m_memrd = 0; m_memwr = 0;
    end else if (!stall) begin
      r = ex_result;
`ifdef SATURATE_EN
      if ((ex_opcode == 4'd0 || ex_opcode == 4'd1) && ex_ovfl)
        r = ex_result[15] ? 16'h7FFF : 16'h8000;
`endif
      m_valid  = ex_valid;
      m_result = r;
      m_store  = ex_store_data;
      m_rd     = ex_rd;
      m_regwe  = ex_regwe && ex_valid;
      m_memrd  = ex_memrd && ex_valid;
      m_memwr  = ex_memwr && ex_valid;
      if (ex_valid) begin
        if (ex_opcode <= 4'd1) begin
          m_z = (r == 0); m_v = ex_ovfl; m_n = r[15];
        end else if (ex_opcode == 4'd2 || ex_opcode == 4'd4 ||
                     ex_opcode == 4'd5 || ex_opcode == 4'd6) begin
          m_z = (r == 0);
        end
      end
    end
    exp_q.push_back(m_result);
  endtask

  task automatic check_all();
    logic [15:0] er;
    er = exp_q.pop_front();
    chk("mem_valid", 32'(mem_valid), 32'(m_valid));
    chk("mem_result", 32'(mem_result), 32'(er));
    chk("mem_store_data", 32'(mem_store_data), 32'(m_store));
    chk("mem_rd", 32'(mem_rd), 32'(m_rd));
    chk("mem_regwe", 32'(mem_regwe), 32'(m_regwe));
    chk("mem_memrd", 32'(mem_memrd), 32'(m_memrd));
    chk("mem_memwr", 32'(mem_memwr), 32'(m_memwr));
    chk("flag_z", 32'(flag_z), 32'(m_z));
    chk("flag_v", 32'(flag_v), 32'(m_v));
    chk("flag_n", 32'(flag_n), 32'(m_n));
  endtask

  // One clock: model the edge, then sample outputs 1 time unit later.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  // driver tasks
  task automatic drive(input logic v, input logic [3:0] op, input logic [15:0] res,
                       input logic ov, input logic we, input logic mr, input logic mw);
    ex_valid      = v;
    ex_opcode     = op;
    ex_result     = res;
    ex_ovfl       = ov;
    ex_store_data = 16'($urandom);
    ex_rd         = 4'($urandom);
    ex_regwe      = we;
    ex_memrd      = mr;
    ex_memwr      = mw;
  endtask

  task automatic drive_rand();
    drive(1'($urandom), 4'($urandom_range(0, 9)), 16'($urandom),
          1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
  endtask

  initial begin
    rst_n = 0; stall = 1; flush = 1;
    drive_rand();

    // Reset overrides stall and flush.
    repeat (3) begin
      drive_rand();
      step();
    end
    chk("rst_valid", 32'(mem_valid), 0);
    chk("rst_result", 32'(mem_result), 0);
    chk("rst_flags", 32'({flag_z, flag_v, flag_n}), 0);

    // Release; first capture on the next edge.
    rst_n = 1; stall = 0; flush = 0;
    drive(1, 4'd0, 16'h0003, 0, 1, 0, 0);
    step();
    chk("add3_result", 32'(mem_result), 32'h0003);
    chk("add3_flags", 32'({flag_z, flag_v, flag_n}), 32'b000);

    // ADD overflow.
    drive(1, 4'd0, 16'h8001, 1, 1, 0, 0);
    step();
`ifdef SATURATE_EN
    chk("addov_result", 32'(mem_result), 32'h7FFF);
    chk("addov_flags", 32'({flag_z, flag_v, flag_n}), 32'b010);
`else
    chk("addov_result", 32'(mem_result), 32'h8001);
    chk("addov_flags", 32'({flag_z, flag_v, flag_n}), 32'b011);
`endif

    // SUB to zero, then XOR (Z only), then LW (no flags).
    drive(1, 4'd1, 16'h0000, 0, 1, 0, 0);
    step();
    chk("sub0_flags", 32'({flag_z, flag_v, flag_n}), 32'b100);
    drive(1, 4'd2, 16'h00F0, 0, 1, 0, 0);
    step();
    chk("xor_flags", 32'({flag_z, flag_v, flag_n}), 32'b000);
    drive(1, 4'd8, 16'h0000, 1, 1, 1, 0);
    step();
    chk("lw_flags", 32'({flag_z, flag_v, flag_n}), 32'b000);
    chk("lw_memrd", 32'(mem_memrd), 1);

    // Negative full-flag result to make V/N hold observable on a Z-only op.
    drive(1, 4'd1, 16'hF000, 1, 1, 0, 0);
    step();
    drive(1, 4'd5, 16'h0000, 0, 1, 0, 0);
    step();
`ifdef SATURATE_EN
    chk("sra_flags", 32'({flag_z, flag_v, flag_n}), 32'b110);
`else
    chk("sra_flags", 32'({flag_z, flag_v, flag_n}), 32'b111);
`endif

    // Stall three cycles with changing inputs.
    stall = 1;
    repeat (3) begin
      drive(1, 4'd0, 16'($urandom_range(1, 16'hFFFF)), 1'($urandom), 1, 1, 1);
      step();
    end
    stall = 0;
    drive(1, 4'd4, 16'h0000, 0, 1, 0, 0);
    step();
    chk("sll_z", 32'(flag_z), 1);
    chk("sll_result", 32'(mem_result), 0);

    // Flush wins over stall.
    stall = 1; flush = 1;
    drive(1, 4'd0, 16'h1234, 0, 0, 0, 1);
    step();
    chk("flush_valid", 32'(mem_valid), 0);
    chk("flush_memwr", 32'(mem_memwr), 0);
    stall = 0; flush = 0;

    // Bubble with stray control bits.
    drive(0, 4'd0, 16'h8000, 1, 1, 1, 1);
    step();
    chk("bubble_regwe", 32'(mem_regwe), 0);

    // Reset mid-stall.
    drive_rand(); step();
    stall = 1; rst_n = 0;
    step();
    chk("rst_stall_valid", 32'(mem_valid), 0);
    rst_n = 1; stall = 0;

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      rst_n = ($urandom_range(0, 49) != 0);
      stall = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 7) == 0);
      drive_rand();
      if ($urandom_range(0, 5) == 0) ex_result = 16'h0000;
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
